// File: rtl/can_tail_if.sv
// can_tail_if: bus-side signal bundle of the CAN transmit frame-tail sequencer.
//   Start        - one-cycle request, asserted with the last CRC bit
//   RX           - bus readback (1 = recessive, 0 = dominant)
//   TX           - bit driven onto the bus
//   EOF_Flag     - active-low, low while End Of Frame is on the bus
//   Busy         - sequencer not idle
//   Ack_Error    - active-low one-cycle pulse, no dominant ACK seen
//   Form_Error   - active-low one-cycle pulse, dominant bit in a fixed-form field
//   Tx_Ok        - one-cycle pulse, EOF completed cleanly
//   Overload     - one-cycle pulse, dominant in intermission bit 1 or 2
//   Sof_Detected - one-cycle pulse, dominant in intermission bit 3
//   Done         - one-cycle pulse, tail sequence finished normally
// The slave modport is the sequencer side, the master modport the controller side.
interface can_tail_if;
    logic Start;
    logic RX;
    logic TX;
    logic EOF_Flag;
    logic Busy;
    logic Ack_Error;
    logic Form_Error;
    logic Tx_Ok;
    logic Overload;
    logic Sof_Detected;
    logic Done;

    modport master (
        output Start, RX,
        input  TX, EOF_Flag, Busy, Ack_Error, Form_Error,
               Tx_Ok, Overload, Sof_Detected, Done
    );

    modport slave (
        input  Start, RX,
        output TX, EOF_Flag, Busy, Ack_Error, Form_Error,
               Tx_Ok, Overload, Sof_Detected, Done
    );
endinterface

// File: rtl/can_tail_tx.sv
// can_tail_tx: transmit-side CAN frame-tail sequencer.
// After the last CRC bit it walks CRC delimiter, ACK slot, ACK delimiter,
// 7 EOF bits and 3 intermission bits, one per SP edge, checking the bus
// readback of each bit and reporting ACK, form, overload and SOF events.
// Ports:
//   SP    - bit-rate clock, one rising edge per bit at the sample point
//   reset - synchronous active-high reset
//   bus   - can_tail_if.slave (Start/RX in, TX and status flags out)
// All outputs are registered; pulses appear in the cycle after the sample.
module can_tail_tx (
    input  logic         SP,
    input  logic         reset,
    can_tail_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CRC_DEL  = 3'd1,
        S_ACK_SLOT = 3'd2,
        S_ACK_DEL  = 3'd3,
        S_EOF      = 3'd4,
        S_IFS      = 3'd5
    } state_t;

    // Bit counter increment that holds at all-ones instead of wrapping.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        if (v == 3'd7) begin
            sat_inc = 3'd7;
        end else begin
            sat_inc = v + 3'd1;
        end
    endfunction

    state_t     r_state;
    logic [2:0] r_cnt;
    logic       r_tx;
    logic       r_eof_flag;
    logic       r_busy;
    logic       r_ack_error;
    logic       r_form_error;
    logic       r_tx_ok;
    logic       r_overload;
    logic       r_sof_detected;
    logic       r_done;

    state_t     w_state_nx;
    logic [2:0] w_cnt_nx;
    logic       w_ack_error;
    logic       w_form_error;
    logic       w_tx_ok;
    logic       w_overload;
    logic       w_sof_detected;
    logic       w_done;

    // Next-state and next-pulse decode from the bit sampled on this edge.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_ack_error    = 1'b1;
        w_form_error   = 1'b1;
        w_tx_ok        = 1'b0;
        w_overload     = 1'b0;
        w_sof_detected = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Start) begin
                    w_state_nx = S_CRC_DEL;
                    w_cnt_nx   = 3'd0;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_CRC_DEL: begin
                w_cnt_nx = 3'd0;
                if (!bus.RX) begin
                    w_form_error = 1'b0;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_state_nx   = S_ACK_SLOT;
                end
            end
            S_ACK_SLOT: begin
                w_cnt_nx = 3'd0;
                // Receivers must overwrite our recessive ACK with dominant.
                if (bus.RX) begin
                    w_ack_error = 1'b0;
                    w_state_nx  = S_IDLE;
                end else begin
                    w_state_nx  = S_ACK_DEL;
                end
            end
            S_ACK_DEL: begin
                w_cnt_nx = 3'd0;
                if (!bus.RX) begin
                    w_form_error = 1'b0;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_state_nx   = S_EOF;
                end
            end
            S_EOF: begin
                if (!bus.RX) begin
                    // Dominant on any EOF bit, the last one included, is a form error.
                    w_form_error = 1'b0;
                    w_state_nx   = S_IDLE;
                    w_cnt_nx     = 3'd0;
                end else if (r_cnt == 3'd6) begin
                    w_tx_ok    = 1'b1;
                    w_state_nx = S_IFS;
                    w_cnt_nx   = 3'd0;
                end else begin
                    w_cnt_nx   = sat_inc(r_cnt);
                end
            end
            S_IFS: begin
                if (r_cnt == 3'd2) begin
                    // Third intermission bit: dominant here is a new SOF, not overload.
                    w_done         = 1'b1;
                    w_sof_detected = ~bus.RX;
                    w_state_nx     = S_IDLE;
                    w_cnt_nx       = 3'd0;
                end else if (!bus.RX) begin
                    w_overload = 1'b1;
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = 3'd0;
                end else begin
                    w_cnt_nx   = sat_inc(r_cnt);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = 3'd0;
            end
        endcase
    end

    // State, counter and registered outputs; reset overrides every action.
    always_ff @(posedge SP) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 3'd0;
            r_tx           <= 1'b1;
            r_eof_flag     <= 1'b1;
            r_busy         <= 1'b0;
            r_ack_error    <= 1'b1;
            r_form_error   <= 1'b1;
            r_tx_ok        <= 1'b0;
            r_overload     <= 1'b0;
            r_sof_detected <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_cnt          <= w_cnt_nx;
            r_tx           <= 1'b1;
            r_eof_flag     <= (w_state_nx != S_EOF);
            r_busy         <= (w_state_nx != S_IDLE);
            r_ack_error    <= w_ack_error;
            r_form_error   <= w_form_error;
            r_tx_ok        <= w_tx_ok;
            r_overload     <= w_overload;
            r_sof_detected <= w_sof_detected;
            r_done         <= w_done;
        end
    end

    assign bus.TX           = r_tx;
    assign bus.EOF_Flag     = r_eof_flag;
    assign bus.Busy         = r_busy;
    assign bus.Ack_Error    = r_ack_error;
    assign bus.Form_Error   = r_form_error;
    assign bus.Tx_Ok        = r_tx_ok;
    assign bus.Overload     = r_overload;
    assign bus.Sof_Detected = r_sof_detected;
    assign bus.Done         = r_done;

endmodule

// File: tb/tb_can_tail_tx.sv
// Bench for can_tail_tx: directed tail scenarios followed by random traffic,
// every cycle checked against a position-in-frame reference model.
module tb_can_tail_tx;

    logic SP;
    logic reset;
    int   checks;
    int   failures;

    can_tail_if bus ();

    can_tail_tx dut (
        .SP    (SP),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial SP = 1'b0;
    always #5 SP = ~SP;

    // Reference model: m_pos counts SP edges since the accepted Start.
    // Bit k of the tail is sampled at edge k: 1 CRC delimiter, 2 ACK slot,
    // 3 ACK delimiter, 4..10 EOF, 11..13 intermission.
    bit m_active;
    int m_pos;
    bit e_tx, e_eof, e_busy, e_ack, e_form, e_txok, e_ovl, e_sof, e_done;

    task automatic model_edge(input bit rst, input bit st, input bit rx);
        e_ack = 1'b1; e_form = 1'b1; e_txok = 1'b0;
        e_ovl = 1'b0; e_sof = 1'b0; e_done = 1'b0;
        e_tx  = 1'b1;
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == 2) begin
                if (rx) begin e_ack = 1'b0; m_active = 1'b0; end
            end else if (m_pos <= 10) begin
                if (!rx) begin e_form = 1'b0; m_active = 1'b0; end
                else if (m_pos == 10) e_txok = 1'b1;
            end else if (m_pos <= 12) begin
                if (!rx) begin e_ovl = 1'b1; m_active = 1'b0; end
            end else begin
                e_done   = 1'b1;
                e_sof    = !rx;
                m_active = 1'b0;
            end
        end
        e_busy = m_active;
        // EOF occupies the cycles after edges 3..9 of the frame.
        e_eof  = !(m_active && m_pos >= 3 && m_pos <= 9);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One bit time: drive inputs away from the edge, clock, then compare.
    task automatic step(input bit rst, input bit st, input bit rx);
        reset     = rst;
        bus.Start = st;
        bus.RX    = rx;
        @(posedge SP);
        #1;
        model_edge(rst, st, rx);
        chk("TX",           bus.TX,           e_tx);
        chk("EOF_Flag",     bus.EOF_Flag,     e_eof);
        chk("Busy",         bus.Busy,         e_busy);
        chk("Ack_Error",    bus.Ack_Error,    e_ack);
        chk("Form_Error",   bus.Form_Error,   e_form);
        chk("Tx_Ok",        bus.Tx_Ok,        e_txok);
        chk("Overload",     bus.Overload,     e_ovl);
        chk("Sof_Detected", bus.Sof_Detected, e_sof);
        chk("Done",         bus.Done,         e_done);
    endtask

    // Directed frame: Start at edge 0 (and optionally restart_edge), nominal
    // ACK from receivers, one RX bit inverted at bad_edge, reset at rst_edge.
    task automatic frame(input int bad_edge, input int rst_edge,
                         input int restart_edge, input int n_edges);
        for (int k = 0; k < n_edges; k++) begin
            bit rx;
            bit st;
            rx = !((k == 2) || (restart_edge >= 0 && k == restart_edge + 2));
            if (k == bad_edge) rx = !rx;
            st = (k == 0) || (k == restart_edge);
            step(k == rst_edge, st, rx);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_active  = 1'b0;
        m_pos     = 0;
        reset     = 1'b1;
        bus.Start = 1'b0;
        bus.RX    = 1'b1;

        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        frame(-1, -1, -1, 16);  // nominal
        frame( 2, -1, -1, 16);  // missing ACK
        frame( 6, -1, -1, 16);  // EOF bit 3 dominant
        frame(10, -1, -1, 16);  // EOF bit 7 dominant
        frame( 1, -1, -1, 16);  // CRC delimiter dominant
        frame( 3, -1, -1, 16);  // ACK delimiter dominant
        frame(11, -1, -1, 16);  // overload in intermission bit 1
        frame(12, -1, -1, 16);  // overload in intermission bit 2
        frame(13, -1, -1, 16);  // SOF in intermission bit 3
        frame(-1,  5, -1, 16);  // reset mid-EOF
        frame(-1, 12, -1, 16);  // reset in intermission
        frame(-1, -1,  4, 16);  // Start while busy is ignored
        frame(-1,  0, -1, 6);   // reset and Start together
        frame(-1, -1, 14, 32);  // Start on the Done cycle is accepted

        // Random traffic: ACK usually present, occasional dominant glitches.
        for (int i = 0; i < 600; i++) begin
            bit rx;
            bit st;
            bit rs;
            if (m_active && m_pos == 1) rx = ($urandom_range(7) != 0) ? 1'b0 : 1'b1;
            else                        rx = ($urandom_range(15) != 0) ? 1'b1 : 1'b0;
            st = ($urandom_range(3) == 0);
            rs = ($urandom_range(63) == 0);
            step(rs, st, rx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
